med_filter_frame_ctrl: RTL and testbench

//  Frame-synchronous controller for the 3x3 median-filter stage of the ISP gray path.

---
 rtl/med_ctrl_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 29 ++
 rtl/med_filter_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_med_filter_frame_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/med_ctrl_pkg.sv
// Shared definitions for the median-filter frame controller.
//
// Contents:
//   frame_state_t  frame tracking states (S_WAIT, S_FRAME, S_BLANK)
//   DEF_IMG_W      default expected active pixels per line
//   DEF_IMG_H      default expected active lines per frame
//   DEF_CNT_W      default pixel/line counter width
//   DEF_FRM_W      default frame counter width
package med_ctrl_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FRAME = 2'd1,
    S_BLANK = 2'd2
  } frame_state_t;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_CNT_W = 12;
  localparam int DEF_FRM_W = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Registered 1-bit edge detector for a signal synchronous to clk.
//
// Ports:
//   clk   in   clock
//   din   in   level being watched
//   rise  out  din is high now and was low on the previous edge
//   fall  out  din is low now and was high on the previous edge
//
// The history flop always loads the current level, including while the
// parent block is held in reset. A signal that is already high when reset
// is released therefore does not produce a false rise.
module sync_edge_det (
  input  logic clk,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q;

  // One-cycle history of the watched level.
  always_ff @(posedge clk) begin
    din_q <= din;
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule

// File: rtl/med_filter_frame_ctrl.sv
// Frame-synchronous controller for the 3x3 median filter of the gray path.
// It accepts filter-enable updates over a valid/ready handshake and applies
// them only at frame start. It also counts pixels, lines and frames, and flags
// frames whose geometry differs from IMG_W x IMG_H.
//
// Ports:
//   clk          pixel clock
//   rst_n        synchronous reset, active low
//   cfg_valid    enable-update request
//   cfg_enable   requested filter enable
//   cfg_ready    high when no update is pending
//   per_vsync    frame sync, active high
//   per_href     line valid, active high
//   per_de       pixel valid, active high
//   filter_en    filter enable, changes only at frame start
//   frame_active high while a tracked frame is in progress
//   frame_done   one-cycle pulse at the end of a tracked frame
//   frame_cnt    completed tracked frames, wraps
//   line_cnt     lines counted in the current/last frame
//   size_err     last completed frame had the wrong geometry
//
// Build option:
//   MED_CTRL_AUTO_BYPASS_EN  when defined, the frame start that follows a
//                            malformed frame forces filter_en low.
module med_filter_frame_ctrl
  import med_ctrl_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int CNT_W = DEF_CNT_W,
  parameter int FRM_W = DEF_FRM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic             cfg_enable,
  output logic             cfg_ready,
  input  logic             per_vsync,
  input  logic             per_href,
  input  logic             per_de,
  output logic             filter_en,
  output logic             frame_active,
  output logic             frame_done,
  output logic [FRM_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic             size_err
);

  localparam logic [CNT_W-1:0] IMG_W_C = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] IMG_H_C = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  frame_state_t     state;
  logic [CNT_W-1:0] pix_cnt;
  logic             frame_err;
  logic             pend_valid;
  logic             pend_enable;

  logic             vs_rise, vs_fall;
  logic             hr_rise, hr_fall;

  logic [CNT_W-1:0] pix_base, pix_eff, line_eff;
  logic             line_end, err_eff, final_err;
  logic [CNT_W-1:0] final_lines;
  logic             next_fen;
  logic             accept;

  sync_edge_det u_vsync_edge (
    .clk  (clk),
    .din  (per_vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  sync_edge_det u_href_edge (
    .clk  (clk),
    .din  (per_href),
    .rise (hr_rise),
    .fall (hr_fall)
  );

  // A line starts counting from zero even if the previous one never closed.
  // The pixel on the current cycle is folded in so that a line which ends
  // while href is still high (vsync fall) sees its last pixel.
  assign pix_base = hr_rise ? '0 : pix_cnt;
  assign pix_eff  = (per_de && per_href && pix_base != CNT_MAX) ? pix_base + 1'b1 : pix_base;
  assign line_end = hr_fall | (vs_fall & per_href);
  assign line_eff = (line_cnt != CNT_MAX) ? line_cnt + 1'b1 : line_cnt;
  assign err_eff  = frame_err | (pix_eff != IMG_W_C);

  // Geometry as it stands when the frame closes, including a line that ends
  // on the same cycle.
  assign final_lines = line_end ? line_eff : line_cnt;
  assign final_err   = (line_end ? err_eff : frame_err) | (final_lines != IMG_H_C);

  // The update slot is single-entry, so ready is simply "slot empty".
  assign cfg_ready = ~pend_valid;
  assign accept    = cfg_valid & cfg_ready;

  // This block picks the enable value that takes effect at the next frame
  // start. A malformed previous frame can override it when auto-bypass is built in.
  always_comb begin
    next_fen = filter_en;
    if (pend_valid) next_fen = pend_enable;
`ifdef MED_CTRL_AUTO_BYPASS_EN
    if (size_err) next_fen = 1'b0;
`else
`endif
  end

  // Frame tracking, geometry counting and handshake state. The pending slot is
  // consumed at every vsync rise. An accept on that same cycle is written
  // afterwards, so it stays pending for the following frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_WAIT;
      pix_cnt      <= '0;
      frame_err    <= 1'b0;
      pend_valid   <= 1'b0;
      pend_enable  <= 1'b0;
      filter_en    <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      line_cnt     <= '0;
      size_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (vs_rise) begin
        filter_en  <= next_fen;
        pend_valid <= 1'b0;
      end
      if (accept) begin
        pend_valid  <= 1'b1;
        pend_enable <= cfg_enable;
      end

      case (state)
        S_WAIT, S_BLANK: begin
          if (vs_rise) begin
            state        <= S_FRAME;
            frame_active <= 1'b1;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            frame_err    <= 1'b0;
          end
        end
        S_FRAME: begin
          if (line_end) begin
            line_cnt  <= line_eff;
            frame_err <= err_eff;
            pix_cnt   <= '0;
          end else begin
            pix_cnt <= pix_eff;
          end
          if (vs_fall) begin
            state        <= S_BLANK;
            frame_active <= 1'b0;
            frame_done   <= 1'b1;
            frame_cnt    <= frame_cnt + 1'b1;
            size_err     <= final_err;
          end
        end
        default: begin
          state        <= S_WAIT;
          frame_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_med_filter_frame_ctrl.sv
// Self-checking bench for med_filter_frame_ctrl with IMG_W=8, IMG_H=4,
// CNT_W=4, FRM_W=2. The stimulus drives whole frames with randomized pixel
// gaps, line lengths and config requests. A reference model records the
// expected filter enable at each frame start and the expected geometry result
// at each frame end. A monitor compares those records whenever the DUT
// reports a frame start or a frame_done pulse.
// Honors MED_CTRL_AUTO_BYPASS_EN in the reference model.
module tb_med_filter_frame_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int CNT_W = 4;
  localparam int FRM_W = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             cfg_valid, cfg_enable, cfg_ready;
  logic             per_vsync, per_href, per_de;
  logic             filter_en, frame_active, frame_done, size_err;
  logic [FRM_W-1:0] frame_cnt;
  logic [CNT_W-1:0] line_cnt;

  med_filter_frame_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CNT_W (CNT_W),
    .FRM_W (FRM_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_enable   (cfg_enable),
    .cfg_ready    (cfg_ready),
    .per_vsync    (per_vsync),
    .per_href     (per_href),
    .per_de       (per_de),
    .filter_en    (filter_en),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .line_cnt     (line_cnt),
    .size_err     (size_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic fen;
    logic rdy;
  } start_exp_t;

  typedef struct {
    logic [CNT_W-1:0] lines;
    logic             err;
    logic [FRM_W-1:0] fcnt;
  } done_exp_t;

  start_exp_t start_q[$];
  done_exp_t  done_q[$];
  start_exp_t s_exp;
  done_exp_t  d_exp;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_pend, m_pend_val, m_fen, m_last_err;
  int m_frames;

  // Current frame description
  int line_len[32];
  int n_lines;
  bit href_at_fall;

  bit mon_prev_active = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_pend_val = 0; m_fen = 0; m_last_err = 0; m_frames = 0;
  endtask

  // Frame start: the pending update (or the bypass) takes effect. A request on
  // the same cycle only lands in the slot if the slot was empty beforehand.
  task automatic model_frame_start(input bit coin_cfg, input bit coin_val);
    bit was_pend;
    bit bypass;
    start_exp_t e;
    was_pend = m_pend;
    bypass = 1'b0;
`ifdef MED_CTRL_AUTO_BYPASS_EN
    bypass = m_last_err;
`endif
    if (bypass) begin
      m_fen  = 1'b0;
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_fen  = m_pend_val;
      m_pend = 1'b0;
    end
    if (coin_cfg && !was_pend) begin
      m_pend     = 1'b1;
      m_pend_val = coin_val;
    end
    e.fen = m_fen;
    e.rdy = !m_pend;
    start_q.push_back(e);
  endtask

  task automatic model_frame_end();
    done_exp_t e;
    int lines;
    bit err;
    lines = (n_lines > CNT_SAT) ? CNT_SAT : n_lines;
    err = (lines != IMG_H);
    for (int i = 0; i < n_lines; i++)
      if (line_len[i] != IMG_W) err = 1'b1;
    m_frames++;
    e.lines = CNT_W'(lines);
    e.err   = err;
    e.fcnt  = FRM_W'(m_frames % (1 << FRM_W));
    m_last_err = err;
    done_q.push_back(e);
  endtask

  // Single-cycle config request issued during blanking
  task automatic apply_cfg(input bit val);
    if (!m_pend) begin
      m_pend     = 1'b1;
      m_pend_val = val;
    end
    cfg_valid  = 1'b1;
    cfg_enable = val;
    tick(1);
    cfg_valid = 1'b0;
    check_output("cfg_ready after request", cfg_ready, 0);
    tick(1);
  endtask

  // Drives one full frame from line_len/n_lines/href_at_fall
  task automatic apply_stimulus(input bit coin_cfg, input bit coin_val);
    int got;
    model_frame_start(coin_cfg, coin_val);
    per_vsync  = 1'b1;
    cfg_valid  = coin_cfg;
    cfg_enable = coin_val;
    tick(1);
    cfg_valid = 1'b0;
    tick(1 + $urandom_range(0, 2));
    for (int i = 0; i < n_lines; i++) begin
      got = 0;
      while (got < line_len[i]) begin
        per_href = 1'b1;
        per_de   = ($urandom_range(0, 3) != 0);
        if (per_de) got++;
        tick(1);
      end
      per_de = 1'b0;
      if (!(i == n_lines - 1 && href_at_fall)) begin
        per_href = 1'b0;
        per_de   = $urandom_range(0, 1) != 0;
        tick(1 + $urandom_range(0, 1));
        per_de = 1'b0;
      end
    end
    if (!href_at_fall) tick(1);
    model_frame_end();
    per_vsync = 1'b0;
    tick(1);
    per_href = 1'b0;
    per_de   = 1'b0;
    tick(3);
  endtask

  task automatic set_clean_frame();
    n_lines = IMG_H;
    href_at_fall = 1'b0;
    for (int i = 0; i < n_lines; i++) line_len[i] = IMG_W;
  endtask

  // Monitor: pops expectations whenever the DUT signals a frame start or end
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (frame_active === 1'b1 && !mon_prev_active) begin
          if (start_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected frame start: got frame_active=1 expected 0");
          end else begin
            s_exp = start_q.pop_front();
            check_output("filter_en at frame start", filter_en, s_exp.fen);
            check_output("cfg_ready at frame start", cfg_ready, s_exp.rdy);
          end
        end
        if (frame_done === 1'b1) begin
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected frame_done: got 1 expected 0");
          end else begin
            d_exp = done_q.pop_front();
            check_output("line_cnt at frame_done", line_cnt, d_exp.lines);
            check_output("size_err at frame_done", size_err, d_exp.err);
            check_output("frame_cnt at frame_done", frame_cnt, d_exp.fcnt);
          end
        end
      end
      mon_prev_active = (frame_active === 1'b1);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_enable = 1'b0;
    per_vsync = 1'b0; per_href = 1'b0; per_de = 1'b0;
    model_reset();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_output("reset cfg_ready", cfg_ready, 1);
    check_output("reset filter_en", filter_en, 0);
    check_output("reset frame_cnt", frame_cnt, 0);

    // Enable the filter, then reset in the middle of an active line
    apply_cfg(1'b1);
    model_frame_start(1'b0, 1'b0);
    per_vsync = 1'b1;
    tick(2);
    per_href = 1'b1; per_de = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    model_reset();
    check_output("midframe reset cfg_ready", cfg_ready, 1);
    check_output("midframe reset filter_en", filter_en, 0);
    check_output("midframe reset frame_active", frame_active, 0);
    check_output("midframe reset frame_done", frame_done, 0);
    check_output("midframe reset frame_cnt", frame_cnt, 0);
    check_output("midframe reset line_cnt", line_cnt, 0);
    check_output("midframe reset size_err", size_err, 0);
    tick(3);
    per_href = 1'b0; per_de = 1'b0;
    tick(2);
    per_vsync = 1'b0;
    tick(3);
    check_output("no frame tracked after reset", frame_active, 0);

    // Request in blanking, then four clean frames for the frame_cnt wrap
    apply_cfg(1'b1);
    set_clean_frame();
    for (int f = 0; f < 4; f++) apply_stimulus(1'b0, 1'b0);

    // Request coincident with vsync rise lands one frame late
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0);

    // Short line, then a pending enable across the following frame start
    apply_cfg(1'b1);
    set_clean_frame();
    line_len[1] = IMG_W - 1;
    apply_stimulus(1'b0, 1'b0);
    apply_cfg(1'b1);
    set_clean_frame();
    apply_stimulus(1'b0, 1'b0);
    apply_cfg(1'b1);
    apply_stimulus(1'b0, 1'b0);

    // Last line still active when vsync falls
    set_clean_frame();
    href_at_fall = 1'b1;
    apply_stimulus(1'b0, 1'b0);

    // Line counter saturation
    set_clean_frame();
    n_lines = CNT_SAT + 2;
    for (int i = 0; i < n_lines; i++) line_len[i] = IMG_W;
    apply_stimulus(1'b0, 1'b0);

    // Randomized frames and requests
    for (int f = 0; f < 14; f++) begin
      n_lines = ($urandom_range(0, 1) != 0) ? IMG_H : int'($urandom_range(3, 5));
      for (int i = 0; i < n_lines; i++)
        line_len[i] = ($urandom_range(0, 3) != 0) ? IMG_W : int'($urandom_range(6, 10));
      href_at_fall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) != 0) apply_cfg($urandom_range(0, 1) != 0);
      apply_stimulus($urandom_range(0, 4) == 0, $urandom_range(0, 1) != 0);
    end

    tick(5);
    check_output("frame start expectations drained", start_q.size(), 0);
    check_output("frame done expectations drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
